// File: rtl/flash_bus_ctrl_pkg.sv
// Shared types and default timing for the parallel NOR flash controller.
package flash_bus_ctrl_pkg;

    typedef enum logic [3:0] {
        RST_PULSE,
        RST_RECOVER,
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        RD_PAGE,
        RD_TURN,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_ACCESS  = 6;
    localparam int DEF_T_PAGE    = 3;
    localparam int DEF_T_WE      = 4;
    localparam int DEF_T_HOLD    = 2;
    localparam int DEF_T_TURN    = 2;
    localparam int DEF_T_RST     = 25;
    localparam int DEF_T_RECOVER = 10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flash_ry_sync.sv
// Two-flop synchroniser for the flash ready/busy pin; resets to busy.
module flash_ry_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ry,
    output logic o_ry
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_ry;
            r_sync <= r_meta;
        end
    end

    assign o_ry = r_sync;

endmodule

// File: rtl/flash_bus_ctrl.sv
// Host-to-NOR-flash bridge with programmable wait states, page bursts and reset pulse.
// Read data appears T_SETUP+T_ACCESS edges after accept; waitrequest holds the host while busy.
module flash_bus_ctrl
    import flash_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 16,
    parameter int PAGE_W    = 3,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_ACCESS  = DEF_T_ACCESS,
    parameter int T_PAGE    = DEF_T_PAGE,
    parameter int T_WE      = DEF_T_WE,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int T_TURN    = DEF_T_TURN,
    parameter int T_RST     = DEF_T_RST,
    parameter int T_RECOVER = DEF_T_RECOVER,
    parameter int RY_GATE   = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [PAGE_W:0]   host_burstcount,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_flash_rst,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rdata_valid,
    output logic              FL_CE_N,
    output logic              FL_OE_N,
    output logic              FL_WE_N,
    output logic              FL_RESET_N,
    output logic              FL_WP_N,
    input  logic              FL_RY,
    output logic [ADDR_W-1:0] FS_ADDR,
    output logic [DATA_W-1:0] FS_DQ_OUT,
    output logic              FS_DQ_OE,
    input  logic [DATA_W-1:0] FS_DQ_IN
);

    localparam int T_MAX = max2(max2(max2(T_SETUP, T_ACCESS), max2(T_PAGE, T_WE)),
                                max2(max2(T_HOLD, T_TURN), max2(T_RST, T_RECOVER)));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PAGE_W:0]     r_left;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_rst_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_dq_out;
    logic                r_dq_oe;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvld;

    logic w_ry;
    logic w_cnt_zero;
    logic w_dispatch;
    logic w_ready;
    logic w_accept;

    flash_ry_sync u_ry_sync (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_ry  (FL_RY),
        .o_ry  (w_ry)
    );

    // The last write-hold cycle doubles as an idle slot so back-to-back
    // writes start exactly T_SETUP+T_WE+T_HOLD edges apart.
    assign w_cnt_zero = (r_cnt == '0);
    assign w_dispatch = (r_state == IDLE) || ((r_state == WR_HOLD) && w_cnt_zero);
    assign w_ready    = w_dispatch && ((RY_GATE == 0) || w_ry);
    assign w_accept   = w_ready && (host_read || host_write);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= RST_PULSE;
            r_cnt    <= CNT_W'(T_RST - 1);
            r_left   <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_rst_n  <= 1'b0;
            r_addr   <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_rdata  <= '0;
            r_rvld   <= 1'b0;
        end else begin
            r_rvld <= 1'b0;
            if (w_dispatch && host_flash_rst) begin
                r_state <= RST_PULSE;
                r_cnt   <= CNT_W'(T_RST - 1);
                r_rst_n <= 1'b0;
                r_ce_n  <= 1'b1;
                r_oe_n  <= 1'b1;
                r_we_n  <= 1'b1;
                r_dq_oe <= 1'b0;
            end else if (w_accept) begin
                r_ce_n <= 1'b0;
                r_addr <= host_addr;
                r_cnt  <= CNT_W'(T_SETUP - 1);
                if (host_write) begin
                    r_state  <= WR_SETUP;
                    r_dq_out <= host_wdata;
                    r_dq_oe  <= 1'b1;
                end else begin
                    r_state <= RD_SETUP;
                    r_dq_oe <= 1'b0;
                    r_left  <= (host_burstcount == '0) ? {{PAGE_W{1'b0}}, 1'b1} : host_burstcount;
                end
            end else begin
                case (r_state)
                    RST_PULSE: begin
                        if (w_cnt_zero) begin
                            r_state <= RST_RECOVER;
                            r_rst_n <= 1'b1;
                            r_cnt   <= CNT_W'(T_RECOVER - 1);
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    RST_RECOVER: begin
                        if (w_cnt_zero) r_state <= IDLE;
                        else            r_cnt   <= r_cnt - 1'b1;
                    end
                    RD_SETUP: begin
                        if (w_cnt_zero) begin
                            r_state <= RD_ACCESS;
                            r_oe_n  <= 1'b0;
                            r_cnt   <= CNT_W'(T_ACCESS - 1);
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    RD_ACCESS, RD_PAGE: begin
                        if (w_cnt_zero) begin
                            r_rdata <= FS_DQ_IN;
                            r_rvld  <= 1'b1;
                            if (r_left <= 1) begin
                                r_state <= RD_TURN;
                                r_ce_n  <= 1'b1;
                                r_oe_n  <= 1'b1;
                                r_cnt   <= CNT_W'(T_TURN - 1);
                            end else begin
                                // Page bursts wrap within the page; upper address bits stay put.
                                r_state              <= RD_PAGE;
                                r_left               <= r_left - 1'b1;
                                r_addr[PAGE_W-1:0]   <= r_addr[PAGE_W-1:0] + 1'b1;
                                r_cnt                <= CNT_W'(T_PAGE - 1);
                            end
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    RD_TURN: begin
                        if (w_cnt_zero) r_state <= IDLE;
                        else            r_cnt   <= r_cnt - 1'b1;
                    end
                    WR_SETUP: begin
                        if (w_cnt_zero) begin
                            r_state <= WR_PULSE;
                            r_we_n  <= 1'b0;
                            r_cnt   <= CNT_W'(T_WE - 1);
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    WR_PULSE: begin
                        if (w_cnt_zero) begin
                            r_state <= WR_HOLD;
                            r_we_n  <= 1'b1;
                            r_cnt   <= CNT_W'(T_HOLD - 1);
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    WR_HOLD: begin
                        if (w_cnt_zero) begin
                            r_state <= IDLE;
                            r_ce_n  <= 1'b1;
                            r_dq_oe <= 1'b0;
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign host_waitrequest = !w_ready;
    assign host_rdata       = r_rdata;
    assign host_rdata_valid = r_rvld;
    assign FL_CE_N          = r_ce_n;
    assign FL_OE_N          = r_oe_n;
    assign FL_WE_N          = r_we_n;
    assign FL_RESET_N       = r_rst_n;
    assign FL_WP_N          = 1'b1;
    assign FS_ADDR          = r_addr;
    assign FS_DQ_OUT        = r_dq_out;
    assign FS_DQ_OE         = r_dq_oe;

endmodule

// File: tb/tb_flash_bus_ctrl.sv
// Self-checking bench for flash_bus_ctrl: scenario tasks with a read-data scoreboard.
module tb_flash_bus_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [26:0] host_addr;
    logic        host_read;
    logic        host_write;
    logic [3:0]  host_burstcount;
    logic [15:0] host_wdata;
    logic        host_flash_rst;
    logic        host_waitrequest;
    logic [15:0] host_rdata;
    logic        host_rdata_valid;
    logic        FL_CE_N, FL_OE_N, FL_WE_N, FL_RESET_N, FL_WP_N;
    logic        FL_RY;
    logic [26:0] FS_ADDR;
    logic [15:0] FS_DQ_OUT;
    logic        FS_DQ_OE;
    logic [15:0] FS_DQ_IN;

    int n_tests = 0;
    int n_fail = 0;
    int vld_total = 0;
    int contention = 0;
    logic [15:0] sb[$];

    flash_bus_ctrl dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .host_addr(host_addr), .host_read(host_read), .host_write(host_write),
        .host_burstcount(host_burstcount), .host_wdata(host_wdata),
        .host_flash_rst(host_flash_rst), .host_waitrequest(host_waitrequest),
        .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
        .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N),
        .FL_RESET_N(FL_RESET_N), .FL_WP_N(FL_WP_N), .FL_RY(FL_RY),
        .FS_ADDR(FS_ADDR), .FS_DQ_OUT(FS_DQ_OUT), .FS_DQ_OE(FS_DQ_OE),
        .FS_DQ_IN(FS_DQ_IN)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [15:0] flash_word(input logic [26:0] a);
        return (a == 27'h0001234) ? 16'hBEEF : (a[15:0] ^ 16'hA5A5);
    endfunction

    always_comb FS_DQ_IN = (!FL_CE_N && !FL_OE_N) ? flash_word(FS_ADDR) : 16'h0BAD;

    always @(negedge CLOCK_50) begin
        if (host_rdata_valid === 1'b1) vld_total++;
        if (FS_DQ_OE === 1'b1 && FL_OE_N === 1'b0) contention++;
    end

    // Called at a negedge; returns just after the accepting posedge.
    task automatic drive_cmd(input logic rd, input logic wr, input logic [26:0] a,
                             input logic [3:0] bc, input logic [15:0] wd,
                             output bit ok, output int waited);
        host_read = rd; host_write = wr; host_addr = a; host_burstcount = bc; host_wdata = wd;
        ok = 1'b0; waited = 0;
        while (!ok && waited < 100) begin
            if (host_waitrequest === 1'b0) begin
                @(posedge CLOCK_50);
                ok = 1'b1;
            end else begin
                @(negedge CLOCK_50);
                waited++;
            end
        end
    endtask

    task automatic test_reset(input int hold);
        int lo, rec, bad;
        reset = 1'b1; host_read = 1'b0; host_write = 1'b0; host_flash_rst = 1'b0;
        repeat (hold) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n_tests++;
        if ({FL_CE_N, FL_OE_N, FL_WE_N, FL_RESET_N, FL_WP_N, FS_DQ_OE, host_waitrequest, host_rdata_valid} !== 8'b11101010
            || FS_ADDR !== 27'h0 || FS_DQ_OUT !== 16'h0 || host_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: ctl=%b addr=%h dq=%h rdata=%h, expected ctl=11101010 addr/dq/rdata=0",
                     {FL_CE_N, FL_OE_N, FL_WE_N, FL_RESET_N, FL_WP_N, FS_DQ_OE, host_waitrequest, host_rdata_valid},
                     FS_ADDR, FS_DQ_OUT, host_rdata);
        end
        reset = 1'b0;
        lo = 0; rec = 0; bad = 0;
        while (FL_RESET_N === 1'b0 && lo < 200) begin
            lo++;
            if ({FL_CE_N, FL_OE_N, FL_WE_N, FL_WP_N, FS_DQ_OE, host_waitrequest, host_rdata_valid} !== 7'b1111010) bad++;
            @(negedge CLOCK_50);
        end
        while (host_waitrequest === 1'b1 && rec < 200) begin
            rec++;
            if (FL_RESET_N !== 1'b1 || FL_CE_N !== 1'b1) bad++;
            @(negedge CLOCK_50);
        end
        n_tests++;
        if (lo != 25) begin n_fail++; $display("FAIL reset_pulse_len: got %0d cycles, expected 25", lo); end
        n_tests++;
        if (rec != 10) begin n_fail++; $display("FAIL reset_recover_len: got %0d cycles, expected 10", rec); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_outputs_during_seq: got %0d bad cycles, expected 0", bad); end
    endtask

    task automatic test_single_read();
        bit ok; int w, oe_lo, first_v, free_i, nv;
        logic [15:0] exp;
        sb.push_back(16'hBEEF);
        drive_cmd(1'b1, 1'b0, 27'h0001234, 4'd1, 16'h0, ok, w);
        oe_lo = 0; first_v = -1; free_i = -1; nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (i == 0) host_read = 1'b0;
            if (FL_OE_N === 1'b0) oe_lo++;
            if (host_rdata_valid === 1'b1) begin
                nv++;
                if (first_v < 0) first_v = i;
                n_tests++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL single_read_data: unexpected word %h", host_rdata); end
                else begin
                    exp = sb.pop_front();
                    if (host_rdata !== exp) begin n_fail++; $display("FAIL single_read_data: got %h, expected %h", host_rdata, exp); end
                end
            end
            if (host_waitrequest === 1'b0 && free_i < 0) free_i = i;
        end
        n_tests++;
        if (!ok || first_v != 8) begin n_fail++; $display("FAIL single_read_latency: accepted=%0d valid at %0d, expected 8", ok, first_v); end
        n_tests++;
        if (oe_lo != 6) begin n_fail++; $display("FAIL single_read_oe_width: got %0d, expected 6", oe_lo); end
        n_tests++;
        if (free_i != 10 || nv != 1) begin n_fail++; $display("FAIL single_read_turn: free at %0d words %0d, expected 10 and 1", free_i, nv); end
    endtask

    task automatic test_page_read();
        logic [26:0] addrs[3];
        int bcs[3];
        addrs = '{27'h0000006, 27'h5ABCDEF, 27'h0001234};
        bcs = '{4, 3, 0};
        for (int t = 0; t < 3; t++) begin
            logic [26:0] exp_a[$];
            logic [26:0] a;
            logic [15:0] exp;
            bit ok; int w, nw, nv, bad_addr, bad_time;
            exp_a.delete();
            nw = (bcs[t] == 0) ? 1 : bcs[t];
            for (int k = 0; k < nw; k++) begin
                a = {addrs[t][26:3], 3'(int'(addrs[t][2:0]) + k)};
                exp_a.push_back(a);
                sb.push_back(flash_word(a));
            end
            drive_cmd(1'b1, 1'b0, addrs[t], 4'(bcs[t]), 16'h0, ok, w);
            nv = 0; bad_addr = 0; bad_time = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge CLOCK_50);
                if (i == 0) host_read = 1'b0;
                if (host_rdata_valid === 1'b1) begin
                    if (i != 8 + 3 * nv) bad_time++;
                    nv++;
                    n_tests++;
                    if (sb.size() == 0) begin n_fail++; $display("FAIL page_read_data[%0d]: unexpected word %h", t, host_rdata); end
                    else begin
                        exp = sb.pop_front();
                        if (host_rdata !== exp) begin n_fail++; $display("FAIL page_read_data[%0d]: got %h, expected %h", t, host_rdata, exp); end
                    end
                end
                if (FL_OE_N === 1'b0 && nv < nw && FS_ADDR !== exp_a[nv]) bad_addr++;
            end
            n_tests++;
            if (!ok || nv != nw) begin n_fail++; $display("FAIL page_read_count[%0d]: got %0d words, expected %0d", t, nv, nw); end
            n_tests++;
            if (bad_addr != 0 || bad_time != 0) begin
                n_fail++; $display("FAIL page_read_seq[%0d]: got %0d addr and %0d timing errors, expected 0", t, bad_addr, bad_time);
            end
        end
    endtask

    task automatic test_write();
        bit ok; int w, we_lo, dq_oe, oe_lo, free_i, bad, v0;
        v0 = vld_total;
        drive_cmd(1'b1, 1'b1, 27'h0000555, 4'd2, 16'h00AA, ok, w);
        we_lo = 0; dq_oe = 0; oe_lo = 0; free_i = -1; bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLOCK_50);
            if (i == 0) begin host_read = 1'b0; host_write = 1'b0; end
            if (FL_WE_N === 1'b0) begin
                we_lo++;
                if (FS_DQ_OUT !== 16'h00AA || FS_ADDR !== 27'h0000555 || FL_CE_N !== 1'b0) bad++;
            end
            if (FS_DQ_OE === 1'b1) dq_oe++;
            if (FL_OE_N === 1'b0) oe_lo++;
            if (host_waitrequest === 1'b0 && free_i < 0) free_i = i;
        end
        n_tests++;
        if (!ok || we_lo != 4) begin n_fail++; $display("FAIL write_we_width: got %0d, expected 4", we_lo); end
        n_tests++;
        if (dq_oe != 8) begin n_fail++; $display("FAIL write_dq_oe_width: got %0d, expected 8", dq_oe); end
        n_tests++;
        if (oe_lo != 0 || vld_total != v0) begin n_fail++; $display("FAIL write_no_read: oe_low=%0d valids=%0d, expected 0 and 0", oe_lo, vld_total - v0); end
        n_tests++;
        if (bad != 0 || free_i != 7) begin n_fail++; $display("FAIL write_bus_hold: bad=%0d free at %0d, expected 0 and 7", bad, free_i); end
    endtask

    task automatic test_back_to_back();
        bit ok; int w, idx;
        drive_cmd(1'b0, 1'b1, 27'h00002AA, 4'd0, 16'h0055, ok, w);
        idx = -1;
        for (int i = 0; i < 20 && idx < 0; i++) begin
            @(negedge CLOCK_50);
            if (i == 0) begin host_addr = 27'h00000AA; host_wdata = 16'hA5A5; end
            if (host_waitrequest === 1'b0) idx = i;
        end
        n_tests++;
        if (FS_ADDR !== 27'h00002AA || FS_DQ_OUT !== 16'h0055) begin
            n_fail++; $display("FAIL b2b_first_hold: got addr %h data %h, expected 2aa 0055", FS_ADDR, FS_DQ_OUT);
        end
        if (idx >= 0) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        host_write = 1'b0;
        n_tests++;
        if (!ok || idx != 7) begin n_fail++; $display("FAIL b2b_accept_slot: got %0d, expected 7", idx); end
        n_tests++;
        if (FS_ADDR !== 27'h00000AA || FS_DQ_OUT !== 16'hA5A5 || FL_CE_N !== 1'b0 || FS_DQ_OE !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_start: got addr %h data %h ce_n %b oe %b, expected 0aa a5a5 0 1",
                               FS_ADDR, FS_DQ_OUT, FL_CE_N, FS_DQ_OE);
        end
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic test_ry_gate();
        int bad;
        @(negedge CLOCK_50);
        FL_RY = 1'b0;
        @(negedge CLOCK_50);
        n_tests++;
        if (host_waitrequest !== 1'b0) begin n_fail++; $display("FAIL ry_busy_latency1: got %b, expected 0", host_waitrequest); end
        @(negedge CLOCK_50);
        n_tests++;
        if (host_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ry_busy_latency2: got %b, expected 1", host_waitrequest); end
        host_write = 1'b1; host_addr = 27'h0000100; host_wdata = 16'h1111;
        bad = 0;
        repeat (6) begin
            @(negedge CLOCK_50);
            if (host_waitrequest !== 1'b1 || FL_CE_N !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL ry_hold_off: got %0d accepted cycles, expected 0", bad); end
        FL_RY = 1'b1;
        @(negedge CLOCK_50);
        n_tests++;
        if (host_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ry_ready_latency1: got %b, expected 1", host_waitrequest); end
        @(negedge CLOCK_50);
        n_tests++;
        if (host_waitrequest !== 1'b0) begin n_fail++; $display("FAIL ry_ready_latency2: got %b, expected 0", host_waitrequest); end
        @(negedge CLOCK_50);
        host_write = 1'b0;
        n_tests++;
        if (FL_CE_N !== 1'b0 || FS_ADDR !== 27'h0000100) begin
            n_fail++; $display("FAIL ry_accept: got ce_n %b addr %h, expected 0 100", FL_CE_N, FS_ADDR);
        end
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic test_flash_rst();
        int lo, rec, v0;
        v0 = vld_total;
        @(negedge CLOCK_50);
        host_flash_rst = 1'b1; host_read = 1'b1; host_addr = 27'h0001234; host_burstcount = 4'd1;
        @(negedge CLOCK_50);
        host_flash_rst = 1'b0; host_read = 1'b0;
        lo = 0; rec = 0;
        n_tests++;
        if (FL_RESET_N !== 1'b0 || FL_CE_N !== 1'b1) begin
            n_fail++; $display("FAIL flash_rst_start: got reset_n %b ce_n %b, expected 0 1", FL_RESET_N, FL_CE_N);
        end
        while (FL_RESET_N === 1'b0 && lo < 200) begin lo++; @(negedge CLOCK_50); end
        while (host_waitrequest === 1'b1 && rec < 200) begin rec++; @(negedge CLOCK_50); end
        n_tests++;
        if (lo != 25 || rec != 10 || vld_total != v0) begin
            n_fail++; $display("FAIL flash_rst_seq: got low %0d recover %0d valids %0d, expected 25 10 0", lo, rec, vld_total - v0);
        end
    endtask

    task automatic test_mid_read_reset();
        bit ok; int w, v0, guard;
        v0 = vld_total;
        drive_cmd(1'b1, 1'b0, 27'h0001234, 4'd1, 16'h0, ok, w);
        @(negedge CLOCK_50);
        host_read = 1'b0;
        guard = 0;
        while (FL_OE_N !== 1'b0 && guard < 10) begin guard++; @(negedge CLOCK_50); end
        @(negedge CLOCK_50);
        n_tests++;
        if (!ok || FL_OE_N !== 1'b0) begin n_fail++; $display("FAIL midreset_reach_access: got oe_n %b, expected 0", FL_OE_N); end
        test_reset(1);
        n_tests++;
        if (vld_total != v0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses, expected 0", vld_total - v0); end
    endtask

    initial begin
        reset = 1'b1; host_addr = '0; host_read = 1'b0; host_write = 1'b0;
        host_burstcount = '0; host_wdata = '0; host_flash_rst = 1'b0; FL_RY = 1'b1;
        test_reset(3);
        test_single_read();
        test_page_read();
        test_write();
        test_back_to_back();
        test_ry_gate();
        test_flash_rst();
        test_mid_read_reset();
        n_tests++;
        if (contention != 0 || sb.size() != 0) begin
            n_fail++; $display("FAIL bus_contention: got %0d cycles, %0d pending words, expected 0 0", contention, sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
